// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Latches a parallel word plus parity configuration, then walks the line
// through start, LSB-first data, optional parity and stop bits by driving
// the select of the downstream 5:1 output mux. The data serializer and
// parity generator live here as well.
// Optional feature: define UART_TX_PRESCALE_EN to add a Prescale input so
// that each bit time lasts Prescale CLK cycles (0 behaves as 1).
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_PRESCALE_EN
    input  logic [5:0]            Prescale,
`endif
    output logic [2:0]            Mux_Sel,
    output logic                  ser_data,
    output logic                  Par_Bit,
    output logic                  Busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bitcnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  w_bit_end;
    logic                  w_last_bit;
    logic                  w_accept;

    assign w_last_bit = (r_bitcnt == LAST_BIT);

    // A request is taken when idle, or in the closing cycle of the stop bit
    // so that frames can be chained with no idle gap.
    assign w_accept = Data_Valid &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

`ifdef UART_TX_PRESCALE_EN
    logic [5:0] r_presc;
    logic [5:0] r_tick;
    logic [5:0] w_presc_eff;

    assign w_presc_eff = (r_presc == 6'd0) ? 6'd1 : r_presc;
    assign w_bit_end   = (r_tick == (w_presc_eff - 6'd1));

    // Tick counter: divides CLK into bit times; rate frozen for the whole frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_presc <= 6'd0;
            r_tick  <= 6'd0;
        end else if (w_accept) begin
            r_presc <= Prescale;
            r_tick  <= 6'd0;
        end else if (r_state != S_IDLE) begin
            r_tick  <= w_bit_end ? 6'd0 : (r_tick + 6'd1);
        end
    end
`else
    assign w_bit_end = 1'b1;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: every non-idle state advances only on a bit boundary.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_START;
            S_START:  if (w_bit_end) w_next_state = S_DATA;
            S_DATA:   if (w_bit_end && w_last_bit)
                          w_next_state = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
            S_STOP:   if (w_bit_end)
                          w_next_state = w_accept ? S_START : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        Mux_Sel = 3'd4;
        Busy    = 1'b1;
        case (r_state)
            S_IDLE:   begin Mux_Sel = 3'd4; Busy = 1'b0; end
            S_START:  Mux_Sel = 3'd0;
            S_DATA:   Mux_Sel = 3'd2;
            S_PARITY: Mux_Sel = 3'd3;
            S_STOP:   Mux_Sel = 3'd1;
            default:  begin Mux_Sel = 3'd4; Busy = 1'b0; end
        endcase
    end

    // Word/config latch, serializer and bit counter. The final data bit is
    // not shifted out so ser_data holds its last value through parity/stop.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= P_DATA;
            r_bitcnt  <= '0;
            r_par_en  <= PAR_EN;
            r_par_bit <= (^P_DATA) ^ PAR_TYP;
        end else if ((r_state == S_DATA) && w_bit_end && !w_last_bit) begin
            r_shift   <= r_shift >> 1;
            r_bitcnt  <= r_bitcnt + CNT_W'(1);
        end
    end

    assign ser_data = r_shift[0];
    assign Par_Bit  = r_par_bit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-scenario tasks compare the DUT
// against an expected frame built from the UART framing rules.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [2:0]   Mux_Sel;
    logic         ser_data;
    logic         Par_Bit;
    logic         Busy;
`ifdef UART_TX_PRESCALE_EN
    logic [5:0]   Prescale;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`ifdef UART_TX_PRESCALE_EN
        .Prescale   (Prescale),
`endif
        .Mux_Sel    (Mux_Sel),
        .ser_data   (ser_data),
        .Par_Bit    (Par_Bit),
        .Busy       (Busy)
    );

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (Mux_Sel !== 3'd4) begin
            errors++;
            $display("FAIL %s idle mux: got %0d want 4", tag, Mux_Sel);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle busy: got %b want 0", tag, Busy);
        end
    endtask

    // Present a request for one edge; on return the DUT should be in its start bit.
    task automatic start_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
    endtask

    // Walk a whole frame and compare every cycle with the expected line sequence.
    // Inputs are scrambled mid-frame; optionally a stray request is issued during
    // data, and optionally the next word is requested in the final stop cycle.
    task automatic run_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                             input int p, input bit mid_dv, input bit chain,
                             input logic [W-1:0] nd, input logic npe, input logic npt,
                             input string tag);
        int   mux_exp[$];
        int   nbits;
        logic ep;
        ep = ((($countones(d)) % 2) != 0) ? ~pt : pt;
        mux_exp = {};
        mux_exp.push_back(0);
        for (int k = 0; k < W; k++) mux_exp.push_back(2);
        if (pe) mux_exp.push_back(3);
        mux_exp.push_back(1);
        nbits = mux_exp.size();
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < p; c++) begin
                checks++;
                if (Mux_Sel !== 3'(mux_exp[b])) begin
                    errors++;
                    $display("FAIL %s mux bit%0d cyc%0d: got %0d want %0d",
                             tag, b, c, Mux_Sel, mux_exp[b]);
                end
                checks++;
                if (Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy bit%0d cyc%0d: got %b want 1", tag, b, c, Busy);
                end
                if (mux_exp[b] == 2) begin
                    checks++;
                    if (ser_data !== d[b-1]) begin
                        errors++;
                        $display("FAIL %s ser_data bit%0d cyc%0d: got %b want %b",
                                 tag, b - 1, c, ser_data, d[b-1]);
                    end
                end
                checks++;
                if (Par_Bit !== ep) begin
                    errors++;
                    $display("FAIL %s par_bit bit%0d: got %b want %b", tag, b, Par_Bit, ep);
                end
                P_DATA     = W'($urandom);
                PAR_EN     = 1'($urandom);
                PAR_TYP    = 1'($urandom);
`ifdef UART_TX_PRESCALE_EN
                Prescale   = 6'($urandom);
`endif
                Data_Valid = (mid_dv && (b == 3) && (c == 0));
                if (chain && (b == nbits - 1) && (c == p - 1)) begin
                    Data_Valid = 1'b1;
                    P_DATA     = nd;
                    PAR_EN     = npe;
                    PAR_TYP    = npt;
`ifdef UART_TX_PRESCALE_EN
                    Prescale   = 6'(p);
`endif
                end
                step();
            end
        end
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        RST        = 1'b0;
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
`ifdef UART_TX_PRESCALE_EN
        Prescale   = 6'd1;
`endif
        repeat (3) step();
        Data_Valid = 1'b0;
        check_idle("reset");
        checks++;
        if (ser_data !== 1'b0) begin
            errors++;
            $display("FAIL reset ser_data: got %b want 0", ser_data);
        end
        checks++;
        if (Par_Bit !== 1'b0) begin
            errors++;
            $display("FAIL reset par_bit: got %b want 0", Par_Bit);
        end
        RST = 1'b1;
        step();
        check_idle("reset_release");
    endtask

    task automatic test_parity_frame();
        start_frame(8'hA5, 1'b1, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "a5_par");
        check_idle("a5_par_end");
    endtask

    task automatic test_no_parity();
        start_frame(8'h01, 1'b0, 1'b0);
        run_frame(8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "01_nopar");
        check_idle("01_nopar_end");
    endtask

    task automatic test_parity_types();
        start_frame(8'h07, 1'b1, 1'b1);
        run_frame(8'h07, 1'b1, 1'b1, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "07_odd");
        check_idle("07_odd_end");
        start_frame(8'h07, 1'b1, 1'b0);
        run_frame(8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "07_even");
        check_idle("07_even_end");
    endtask

    task automatic test_back_to_back();
        start_frame(8'hA5, 1'b1, 1'b1);
        run_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, "b2b_first");
        run_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "b2b_second");
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        start_frame(8'hA5, 1'b1, 1'b1);
        repeat (4) step();
        checks++;
        if (Mux_Sel !== 3'd2 || ser_data !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid pre: got mux %0d ser %b want mux 2 ser 0", Mux_Sel, ser_data);
        end
        RST = 1'b0;
        step();
        RST = 1'b1;
        check_idle("rst_mid");
        checks++;
        if (ser_data !== 1'b0 || Par_Bit !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid regs: got ser %b par %b want 0 0", ser_data, Par_Bit);
        end
        step();
        check_idle("rst_mid_hold");
        d = W'($urandom);
        start_frame(d, 1'b1, 1'b0);
        run_frame(d, 1'b1, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "rst_mid_clean");
        check_idle("rst_mid_clean_end");
    endtask

    task automatic test_random();
        logic [W-1:0] d, nd;
        logic pe, pt, npe, npt;
        bit   ch;
        d  = W'($urandom);
        pe = 1'($urandom);
        pt = 1'($urandom);
        start_frame(d, pe, pt);
        for (int i = 0; i < 20; i++) begin
            ch  = (i != 19) && ($urandom_range(0, 1) == 1);
            nd  = W'($urandom);
            npe = 1'($urandom);
            npt = 1'($urandom);
            run_frame(d, pe, pt, 1, 1'($urandom), ch, nd, npe, npt, "rand");
            if (!ch) begin
                check_idle("rand_gap");
                step();
                start_frame(nd, npe, npt);
            end
            d  = nd;
            pe = npe;
            pt = npt;
        end
        run_frame(d, pe, pt, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "rand_last");
        check_idle("rand_end");
    endtask

`ifdef UART_TX_PRESCALE_EN
    task automatic test_prescale();
        Prescale = 6'd4;
        start_frame(8'h55, 1'b0, 1'b0);
        run_frame(8'h55, 1'b0, 1'b0, 4, 1'b0, 1'b0, '0, 1'b0, 1'b0, "presc4");
        check_idle("presc4_end");
        Prescale = 6'd0;
        start_frame(8'h55, 1'b1, 1'b0);
        run_frame(8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "presc0");
        check_idle("presc0_end");
        Prescale = 6'd3;
        start_frame(8'hC3, 1'b1, 1'b1);
        run_frame(8'hC3, 1'b1, 1'b1, 3, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, "presc3_b2b");
        run_frame(8'h3C, 1'b0, 1'b1, 3, 1'b0, 1'b0, '0, 1'b0, 1'b0, "presc3_second");
        check_idle("presc3_end");
        Prescale = 6'd1;
    endtask
`endif

    initial begin
        test_reset();
        test_parity_frame();
        test_no_parity();
        test_parity_types();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_TX_PRESCALE_EN
        test_prescale();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a parallel byte with a valid strobe and latches it together with the parity configuration.
- Drives the 3-bit output-mux select so the serial line carries idle, start, LSB-first data, optional parity and stop bits in order.
- Contains the data serializer (shift register plus bit counter) and the parity generator, so the 5:1 output mux is its only downstream consumer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal 5..9).

Ports:
- CLK  input  1  transmit clock; all state updates on the rising edge.
- RST  input  1  synchronous active-low reset, sampled on the rising CLK edge.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- Data_Valid  input  1  single-cycle request strobe qualifying P_DATA/PAR_EN/PAR_TYP.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Mux_Sel  output  3  output mux select: 0 start, 1 stop, 2 data, 3 parity, 4 idle.
- ser_data  output  1  current serialized data bit (LSB first).
- Par_Bit  output  1  parity of the latched word.
- Busy  output  1  frame in progress.

Behaviour:
- Reset (RST=0 at a rising edge), including mid-frame:
  - state=IDLE, Mux_Sel=4, Busy=0, ser_data=0, Par_Bit=0.
  - Bit counter=0, data/config latches cleared.
  - Any frame in progress is aborted; no partial bits are emitted after the reset edge.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are decoded from registered state and registers; there is no combinational path from inputs to outputs.
- IDLE: Mux_Sel=4, Busy=0.
  - Data_Valid=1 at edge N latches P_DATA, PAR_EN and PAR_TYP.
  - Par_Bit is computed as (^P_DATA)^PAR_TYP.
  - Moves to START at N+1.
- START: one bit time, Mux_Sel=0, Busy=1, then DATA.
- DATA: DATA_WIDTH bit times, Mux_Sel=2.
  - ser_data = latched bit[k], k=0..DATA_WIDTH-1, LSB first; the shift register shifts right once per bit time.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: one bit time, Mux_Sel=3, then STOP.
- STOP: one bit time, Mux_Sel=1, Busy=1.
  - Data_Valid=1 during the final cycle of STOP: latch the new word, go directly to START (back-to-back frame, no idle gap, Busy stays 1).
  - Otherwise go to IDLE.
- Latency: Data_Valid edge N -> start bit at N+1; frame length 1+DATA_WIDTH+PAR_EN+1 bit times.
- Data_Valid in START/DATA/PARITY or in non-final STOP cycles: ignored (dropped, no queueing); latches unchanged.
- Input changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect on the frame in progress.
- Par_Bit and ser_data hold their values outside the states that use them; only Mux_Sel determines what reaches the line.
- Bit counter width: $clog2(DATA_WIDTH); it clears on entry to START.

Optional Feature:
- Macro: UART_TX_PRESCALE_EN.
- Defined:
  - Adds input Prescale [5:0]. Each bit time lasts Prescale CLK cycles, counted by an internal tick counter; Prescale=0 is treated as 1.
  - Prescale is latched with Data_Valid and held for the whole frame.
  - The back-to-back accept window is the last cycle of the stop bit's final tick.
  - Busy, Mux_Sel and ser_data change only on bit boundaries.
- Undefined: no Prescale port; every bit time is exactly one CLK cycle (CLK is the baud clock).

Test Plan:
- Reset then P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, Data_Valid pulse at N -> Mux_Sel sequence N+1..N+11 = 0,2×8,3,1 then 4; ser_data = 1,0,1,0,0,1,0,1; Par_Bit=0; Busy high N+1..N+11.
- P_DATA=8'h01, PAR_EN=0 -> 10-cycle frame 0,2×8,1; no Mux_Sel=3 ever seen; Busy drops at N+11.
- P_DATA=8'h07, PAR_EN=1, PAR_TYP=1 -> Par_Bit=0; with PAR_TYP=0 -> Par_Bit=1.
- Second Data_Valid (8'h3C) asserted in the final STOP cycle of a frame -> next cycle Mux_Sel=0, Busy never drops, second frame data correct; a Data_Valid during DATA is ignored and the frame is unchanged.
- RST=0 at the 4th data bit -> next cycle Mux_Sel=4, Busy=0, ser_data=0; a subsequent Data_Valid starts a clean frame.
- With UART_TX_PRESCALE_EN, Prescale=4, 8'h55, no parity -> each Mux_Sel value held exactly 4 cycles; frame 40 cycles; Prescale=0 behaves as 1.
